ula_ctrl: RTL

- Sequencing and execute stage that drives the 8x8 register file.
- Accepts one instruction at a time over a valid/ready handshake.
- Reads source operands through the register file read ports (ra1/ra2 -> rd1/rd2), computes the ULA result (including an iterative 8-cycle multiply), and writes back through wa3/wd3/we3.
- Maintains zero/carry flags.

---
 rtl/ula_pkg.sv | 55 +++++
 rtl/ula_alu.sv | 58 +++++
 rtl/ula_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared constants, opcode/state encodings and opcode property helpers for the
// ula_ctrl sequencing/execute stage.
package ula_pkg;

    localparam int DataWidth = 8;
    localparam int AddrWidth = 3;
    localparam int MulCycles = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_ADDI = 4'd8,
        OP_MOVI = 4'd9,
        OP_MUL  = 4'd10,
        OP_CMP  = 4'd11,
        OP_NOP  = 4'd12
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_MUL  = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    // Opcodes that produce a register-file write (rd==0 still suppresses it).
    function automatic logic op_writes(op_t op);
        logic w;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_SHL, OP_SHR, OP_ADDI, OP_MOVI, OP_MUL: w = 1'b1;
            default:                                  w = 1'b0;
        endcase
        return w;
    endfunction

    // Every opcode except the NOP range updates zero/carry.
    function automatic logic op_sets_flags(op_t op);
        logic f;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL,
            OP_SHR, OP_ADDI, OP_MOVI, OP_MUL, OP_CMP: f = 1'b1;
            default:                                  f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/ula_alu.sv
// Combinational ULA datapath for all single-cycle opcodes; MUL is iterated in
// ula_ctrl, so it yields zero here.
module ula_alu
    import ula_pkg::*;
(
    input  op_t                  op,
    input  logic [DataWidth-1:0] a,
    input  logic [DataWidth-1:0] b,
    input  logic [DataWidth-1:0] imm,
    output logic [DataWidth-1:0] result,
    output logic                 carry
);

    logic [DataWidth:0] wide_s;

    // Result and carry/borrow/shift-out selection by opcode
    always_comb begin
        wide_s = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                wide_s = {1'b0, a} + {1'b0, b};
                result = wide_s[DataWidth-1:0];
                carry  = wide_s[DataWidth];
            end
            OP_SUB, OP_CMP: begin
                // The 9th bit of the difference is the borrow (a < b).
                wide_s = {1'b0, a} - {1'b0, b};
                result = wide_s[DataWidth-1:0];
                carry  = wide_s[DataWidth];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[DataWidth-2:0], 1'b0};
                carry  = a[DataWidth-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DataWidth-1:1]};
                carry  = a[0];
            end
            OP_ADDI: begin
                wide_s = {1'b0, a} + {1'b0, imm};
                result = wide_s[DataWidth-1:0];
                carry  = wide_s[DataWidth];
            end
            OP_MOVI: result = imm;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ula_ctrl.sv
// Sequencing/execute stage: accepts one instruction, reads operands from the
// register file, executes (iterative shift-add for MUL) and writes back.
module ula_ctrl
    import ula_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [3:0]           instr_op,
    input  logic [AddrWidth-1:0] instr_rd,
    input  logic [AddrWidth-1:0] instr_rs1,
    input  logic [AddrWidth-1:0] instr_rs2,
    input  logic [DataWidth-1:0] instr_imm,
    output logic [AddrWidth-1:0] ra1,
    output logic [AddrWidth-1:0] ra2,
    input  logic [DataWidth-1:0] rd1,
    input  logic [DataWidth-1:0] rd2,
    output logic [AddrWidth-1:0] wa3,
    output logic [DataWidth-1:0] wd3,
    output logic                 we3,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 busy,
    output logic                 done
);

    localparam int AccWidth = 2 * DataWidth;

    state_t                 state_q, state_d;
    op_t                    op_q, op_d;
    logic [AddrWidth-1:0]   rd_q, rd_d;
    logic [DataWidth-1:0]   imm_q, imm_d;
    logic [AddrWidth-1:0]   ra1_q, ra1_d, ra2_q, ra2_d;
    logic [DataWidth-1:0]   a_q, a_d, b_q, b_d;
    logic [AccWidth-1:0]    acc_q, acc_d, mcand_q, mcand_d;
    logic [DataWidth-1:0]   mplier_q, mplier_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [AddrWidth-1:0]   wa3_q, wa3_d;
    logic [DataWidth-1:0]   wd3_q, wd3_d;
    logic                   we3_q, we3_d, done_q, done_d, busy_q, busy_d;
    logic                   fz_q, fz_d, fc_q, fc_d;
    logic [DataWidth-1:0]   alu_res_s;
    logic                   alu_c_s;
    logic [AccWidth-1:0]    mul_sum_s;

    ula_alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .imm    (imm_q),
        .result (alu_res_s),
        .carry  (alu_c_s)
    );

    assign instr_ready = (state_q == ST_IDLE) && !reset;

    // Next-state and next-output computation for the instruction sequencer
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        ra1_d    = ra1_q;
        ra2_d    = ra2_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        wa3_d    = wa3_q;
        wd3_d    = wd3_q;
        fz_d     = fz_q;
        fc_d     = fc_q;
        we3_d    = 1'b0;
        done_d   = 1'b0;
        mul_sum_s = acc_q + (mplier_q[0] ? mcand_q : {AccWidth{1'b0}});
        case (state_q)
            ST_IDLE: begin
                if (instr_valid && instr_ready) begin
                    op_d    = op_t'(instr_op);
                    rd_d    = instr_rd;
                    imm_d   = instr_imm;
                    ra1_d   = instr_rs1;
                    ra2_d   = instr_rs2;
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                a_d      = rd1;
                b_d      = rd2;
                mcand_d  = {{DataWidth{1'b0}}, rd1};
                mplier_d = rd2;
                acc_d    = '0;
                cnt_d    = 3'd0;
                state_d  = (op_q == OP_MUL) ? ST_MUL : ST_EXEC;
            end
            ST_EXEC: begin
                if (op_sets_flags(op_q)) begin
                    fz_d = (alu_res_s == '0);
                    fc_d = alu_c_s;
                end else begin
                    fz_d = fz_q;
                    fc_d = fc_q;
                end
                wa3_d   = rd_q;
                wd3_d   = alu_res_s;
                we3_d   = op_writes(op_q) && (rd_q != '0);
                done_d  = 1'b1;
                state_d = ST_WB;
            end
            ST_MUL: begin
                // One multiplier bit per cycle, LSB first.
                acc_d    = mul_sum_s;
                mcand_d  = {mcand_q[AccWidth-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[DataWidth-1:1]};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'(MulCycles - 1)) begin
                    fz_d    = (mul_sum_s[DataWidth-1:0] == '0);
                    fc_d    = (mul_sum_s[AccWidth-1:DataWidth] != '0);
                    wa3_d   = rd_q;
                    wd3_d   = mul_sum_s[DataWidth-1:0];
                    we3_d   = (rd_q != '0);
                    done_d  = 1'b1;
                    state_d = ST_WB;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            rd_q     <= '0;
            imm_q    <= '0;
            ra1_q    <= '0;
            ra2_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= 3'd0;
            wa3_q    <= '0;
            wd3_q    <= '0;
            we3_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            fz_q     <= 1'b0;
            fc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            ra1_q    <= ra1_d;
            ra2_q    <= ra2_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
            we3_q    <= we3_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            fz_q     <= fz_d;
            fc_q     <= fc_d;
        end
    end

    assign ra1    = ra1_q;
    assign ra2    = ra2_q;
    assign wa3    = wa3_q;
    assign wd3    = wd3_q;
    assign we3    = we3_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign flag_z = fz_q;
    assign flag_c = fc_q;

endmodule
